// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle RV32I control path and its datapath muxes.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package multicycle_pkg;

   // FSM state encodings
   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_TRAP   = 3'd5;

   // RV32I major opcodes
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // Immediate generator format select
   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   // Next-PC select
   localparam logic [1:0] PC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_TARGET = 2'd1;
   localparam logic [1:0] PC_JALR   = 2'd2;

   // Register write-back source select
   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   // One-hot instruction class produced by the decoder
   typedef struct packed {
      logic op;
      logic opimm;
      logic lui;
      logic auipc;
      logic load;
      logic store;
      logic branch;
      logic jal;
      logic jalr;
      logic illegal;
   } iclass_t;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier: latched opcode -> one-hot instruction class and immediate format.
// Latency: purely combinational.
// Backpressure: none.
module ctrl_decode
   import multicycle_pkg::*;
(
   input  logic [6:0] opcode,
   output iclass_t    cls,
   output logic [2:0] imm_sel
);

   // Classify the opcode; anything unrecognised is flagged illegal with an I-format default
   always_comb begin
      cls     = '0;
      imm_sel = IMM_I;
      case (opcode)
         OPC_OP:     cls.op = 1'b1;
         OPC_OPIMM:  cls.opimm = 1'b1;
         OPC_LOAD:   cls.load = 1'b1;
         OPC_JALR:   cls.jalr = 1'b1;
         OPC_STORE: begin
            cls.store = 1'b1;
            imm_sel   = IMM_S;
         end
         OPC_BRANCH: begin
            cls.branch = 1'b1;
            imm_sel    = IMM_B;
         end
         OPC_LUI: begin
            cls.lui = 1'b1;
            imm_sel = IMM_U;
         end
         OPC_AUIPC: begin
            cls.auipc = 1'b1;
            imm_sel   = IMM_U;
         end
         OPC_JAL: begin
            cls.jal = 1'b1;
            imm_sel = IMM_J;
         end
         default:    cls.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32I core (fetch/decode/exec/mem/wb); MULTICYCLE_CTRL_TRAP_EN adds a sticky illegal-opcode trap.
// Latency: branch/NOP 3 cycles, ALU/LUI/AUIPC/JAL/JALR/store 4, load 5, plus one per mem_ready=0 cycle.
// Backpressure: FETCH and MEM hold mem_req/addr_sel stable until mem_ready; all outputs are quiet in reset and the cycle after.
module multicycle_ctrl
   import multicycle_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       branch_taken,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       addr_sel,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] pc_sel,
   output logic [2:0] imm_sel,
   output logic       alu_src_a,
   output logic       alu_src_b,
   output logic       reg_we,
   output logic [1:0] wb_sel,
   output logic       retire,
   output logic       illegal_instr
);

   logic [2:0] state, state_nxt;
   logic       run;
   logic       ena;
   iclass_t    cls;
   logic [2:0] imm_raw;
   logic       mem_req_c, mem_we_c, addr_sel_c, ir_we_c, pc_we_c;
   logic       alu_src_a_c, alu_src_b_c, reg_we_c, retire_c;
   logic [1:0] pc_sel_c, wb_sel_c;

   // funct3 is carried for the datapath's class handling; the FSM itself never needs it
   logic unused_funct3;
   assign unused_funct3 = ^funct3;

   ctrl_decode u_decode (
      .opcode  (opcode),
      .cls     (cls),
      .imm_sel (imm_raw)
   );

   // Outputs are suppressed while rst is high (no partial PC/reg write) and for one idle cycle after
   assign ena = run & ~rst;

   // State register plus the one-cycle post-reset idle flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_FETCH;
         run   <= 1'b0;
      end else begin
         run <= 1'b1;
         if (run) state <= state_nxt;
      end
   end

`ifdef MULTICYCLE_CTRL_TRAP_EN
   logic ill_q;

   // Sticky illegal flag, set on the way into TRAP and cleared only by reset
   always_ff @(posedge clk) begin
      if (rst)
         ill_q <= 1'b0;
      else if (run && state == ST_DECODE && cls.illegal)
         ill_q <= 1'b1;
   end

   assign illegal_instr = ill_q & ~rst;
`else
   assign illegal_instr = 1'b0;
`endif

   // Next-state and raw datapath controls per state
   always_comb begin
      state_nxt   = state;
      mem_req_c   = 1'b0;
      mem_we_c    = 1'b0;
      addr_sel_c  = 1'b0;
      ir_we_c     = 1'b0;
      pc_we_c     = 1'b0;
      pc_sel_c    = PC_PLUS4;
      alu_src_a_c = 1'b0;
      alu_src_b_c = 1'b0;
      reg_we_c    = 1'b0;
      wb_sel_c    = WB_ALU;
      retire_c    = 1'b0;
      case (state)
         ST_FETCH: begin
            mem_req_c = 1'b1;
            if (mem_ready) begin
               ir_we_c   = 1'b1;
               state_nxt = ST_DECODE;
            end
         end
         ST_DECODE: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
            state_nxt = cls.illegal ? ST_TRAP : ST_EXEC;
`else
            state_nxt = ST_EXEC;
`endif
         end
         ST_EXEC: begin
            alu_src_b_c = cls.opimm | cls.lui | cls.auipc | cls.load | cls.store;
            alu_src_a_c = cls.auipc;
            if (cls.load || cls.store) begin
               state_nxt = ST_MEM;
            end else if (cls.branch) begin
               pc_we_c   = 1'b1;
               pc_sel_c  = branch_taken ? PC_TARGET : PC_PLUS4;
               retire_c  = 1'b1;
               state_nxt = ST_FETCH;
            end else if (cls.illegal) begin
               // Unknown opcode retires as a NOP
               pc_we_c   = 1'b1;
               retire_c  = 1'b1;
               state_nxt = ST_FETCH;
            end else if (cls.op || cls.opimm || cls.lui || cls.auipc || cls.jal || cls.jalr) begin
               state_nxt = ST_WB;
            end
         end
         ST_MEM: begin
            mem_req_c  = 1'b1;
            addr_sel_c = 1'b1;
            mem_we_c   = cls.store;
            if (mem_ready) begin
               if (cls.store) begin
                  pc_we_c   = 1'b1;
                  retire_c  = 1'b1;
                  state_nxt = ST_FETCH;
               end else begin
                  state_nxt = ST_WB;
               end
            end
         end
         ST_WB: begin
            reg_we_c  = 1'b1;
            pc_we_c   = 1'b1;
            retire_c  = 1'b1;
            state_nxt = ST_FETCH;
            if (cls.load)
               wb_sel_c = WB_MEM;
            else if (cls.jal || cls.jalr)
               wb_sel_c = WB_PC4;
            if (cls.jal)
               pc_sel_c = PC_TARGET;
            else if (cls.jalr)
               pc_sel_c = PC_JALR;
         end
`ifdef MULTICYCLE_CTRL_TRAP_EN
         ST_TRAP: state_nxt = ST_TRAP;
`endif
         default: state_nxt = ST_FETCH;
      endcase
   end

   assign mem_req   = mem_req_c & ena;
   assign mem_we    = mem_we_c & ena;
   assign addr_sel  = addr_sel_c & ena;
   assign ir_we     = ir_we_c & ena;
   assign pc_we     = pc_we_c & ena;
   assign pc_sel    = ena ? pc_sel_c : 2'd0;
   assign imm_sel   = ena ? imm_raw : 3'd0;
   assign alu_src_a = alu_src_a_c & ena;
   assign alu_src_b = alu_src_b_c & ena;
   assign reg_we    = reg_we_c & ena;
   assign wb_sel    = ena ? wb_sel_c : 2'd0;
   assign retire    = retire_c & ena;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected output vectors, hand-computed.
// Latency: inputs applied 1ns after posedge, outputs sampled 2ns later.
// Backpressure: mem_ready stalls driven explicitly in the vectors.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       branch_taken;
   logic       mem_ready;
   logic       mem_req, mem_we, addr_sel, ir_we, pc_we;
   logic [1:0] pc_sel;
   logic [2:0] imm_sel;
   logic       alu_src_a, alu_src_b, reg_we;
   logic [1:0] wb_sel;
   logic       retire, illegal_instr;
   logic [16:0] obs;

   int n_chk  = 0;
   int n_pass = 0;

   multicycle_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .opcode        (opcode),
      .funct3        (funct3),
      .branch_taken  (branch_taken),
      .mem_ready     (mem_ready),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .addr_sel      (addr_sel),
      .ir_we         (ir_we),
      .pc_we         (pc_we),
      .pc_sel        (pc_sel),
      .imm_sel       (imm_sel),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .reg_we        (reg_we),
      .wb_sel        (wb_sel),
      .retire        (retire),
      .illegal_instr (illegal_instr)
   );

   always #5 clk = ~clk;

   assign obs = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, imm_sel,
                 alu_src_a, alu_src_b, reg_we, wb_sel, retire, illegal_instr};

   // Expected vector in the same field order as obs
   function automatic logic [16:0] ov(input logic req, input logic we, input logic asel,
                                      input logic irw, input logic pcw, input logic [1:0] pcs,
                                      input logic [2:0] imm, input logic sa, input logic sb,
                                      input logic rw, input logic [1:0] wbs, input logic ret,
                                      input logic ill);
      return {req, we, asel, irw, pcw, pcs, imm, sa, sb, rw, wbs, ret, ill};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // Drive one cycle of inputs, check outputs mid-cycle, advance to just after the next edge
   task automatic step(input string tag, input logic r, input logic rdy, input logic bt,
                       input logic [16:0] exp);
      rst          = r;
      mem_ready    = rdy;
      branch_taken = bt;
      #2;
      chk(tag, {15'd0, obs}, {15'd0, exp});
      @(posedge clk);
      #1;
   endtask

   localparam logic [16:0] Z = 17'd0;

   initial begin
      rst = 1'b1; opcode = 7'b0010011; funct3 = 3'd0; branch_taken = 1'b0; mem_ready = 1'b0;
      @(posedge clk);
      #1;

      // Reset and the idle cycle right after it: everything quiet, mem_ready ignored
      step("rst_a",    1, 1, 0, Z);
      step("rst_b",    1, 0, 0, Z);
      step("rst_idle", 0, 1, 0, Z);

      // ADDI, fetch stalled 3 cycles
      opcode = 7'b0010011;
      step("addi_f0",  0, 0, 0, ov(1,0,0,0,0,0,0,0,0,0,0,0,0));
      step("addi_f1",  0, 0, 0, ov(1,0,0,0,0,0,0,0,0,0,0,0,0));
      step("addi_f2",  0, 0, 0, ov(1,0,0,0,0,0,0,0,0,0,0,0,0));
      step("addi_f3",  0, 1, 0, ov(1,0,0,1,0,0,0,0,0,0,0,0,0));
      step("addi_dec", 0, 1, 0, Z);
      step("addi_ex",  0, 1, 0, ov(0,0,0,0,0,0,0,0,1,0,0,0,0));
      step("addi_wb",  0, 0, 0, ov(0,0,0,0,1,0,0,0,0,1,0,1,0));

      // LW, data phase stalled 2 cycles
      opcode = 7'b0000011;
      step("lw_f",     0, 1, 0, ov(1,0,0,1,0,0,0,0,0,0,0,0,0));
      step("lw_dec",   0, 0, 0, Z);
      step("lw_ex",    0, 0, 0, ov(0,0,0,0,0,0,0,0,1,0,0,0,0));
      step("lw_m0",    0, 0, 0, ov(1,0,1,0,0,0,0,0,0,0,0,0,0));
      step("lw_m1",    0, 0, 0, ov(1,0,1,0,0,0,0,0,0,0,0,0,0));
      step("lw_m2",    0, 1, 0, ov(1,0,1,0,0,0,0,0,0,0,0,0,0));
      step("lw_wb",    0, 0, 0, ov(0,0,0,0,1,0,0,0,0,1,1,1,0));

      // BEQ taken, then not taken
      opcode = 7'b1100011;
      step("beqt_f",   0, 1, 0, ov(1,0,0,1,0,0,2,0,0,0,0,0,0));
      step("beqt_dec", 0, 0, 0, ov(0,0,0,0,0,0,2,0,0,0,0,0,0));
      step("beqt_ex",  0, 0, 1, ov(0,0,0,0,1,1,2,0,0,0,0,1,0));
      step("beqn_f",   0, 1, 0, ov(1,0,0,1,0,0,2,0,0,0,0,0,0));
      step("beqn_dec", 0, 0, 1, ov(0,0,0,0,0,0,2,0,0,0,0,0,0));
      step("beqn_ex",  0, 0, 0, ov(0,0,0,0,1,0,2,0,0,0,0,1,0));

      // JALR
      opcode = 7'b1100111;
      step("jalr_f",   0, 1, 0, ov(1,0,0,1,0,0,0,0,0,0,0,0,0));
      step("jalr_dec", 0, 0, 0, Z);
      step("jalr_ex",  0, 0, 0, Z);
      step("jalr_wb",  0, 0, 0, ov(0,0,0,0,1,2,0,0,0,1,2,1,0));

      // JAL
      opcode = 7'b1101111;
      step("jal_f",    0, 1, 0, ov(1,0,0,1,0,0,4,0,0,0,0,0,0));
      step("jal_dec",  0, 0, 0, ov(0,0,0,0,0,0,4,0,0,0,0,0,0));
      step("jal_ex",   0, 0, 0, ov(0,0,0,0,0,0,4,0,0,0,0,0,0));
      step("jal_wb",   0, 0, 0, ov(0,0,0,0,1,1,4,0,0,1,2,1,0));

      // AUIPC
      opcode = 7'b0010111;
      step("auipc_f",  0, 1, 0, ov(1,0,0,1,0,0,3,0,0,0,0,0,0));
      step("auipc_dec",0, 0, 0, ov(0,0,0,0,0,0,3,0,0,0,0,0,0));
      step("auipc_ex", 0, 0, 0, ov(0,0,0,0,0,0,3,1,1,0,0,0,0));
      step("auipc_wb", 0, 0, 0, ov(0,0,0,0,1,0,3,0,0,1,0,1,0));

      // SW interrupted by reset while the store request is pending
      opcode = 7'b0100011;
      step("swr_f",    0, 1, 0, ov(1,0,0,1,0,0,1,0,0,0,0,0,0));
      step("swr_dec",  0, 0, 0, ov(0,0,0,0,0,0,1,0,0,0,0,0,0));
      step("swr_ex",   0, 0, 0, ov(0,0,0,0,0,0,1,0,1,0,0,0,0));
      step("swr_m0",   0, 0, 0, ov(1,1,1,0,0,0,1,0,0,0,0,0,0));
      step("swr_rst",  1, 1, 0, Z);
      step("swr_idle", 0, 1, 0, Z);
      step("swr_re_f0",0, 0, 0, ov(1,0,0,0,0,0,1,0,0,0,0,0,0));

      // Clean SW after the restart
      step("sw_f",     0, 1, 0, ov(1,0,0,1,0,0,1,0,0,0,0,0,0));
      step("sw_dec",   0, 0, 0, ov(0,0,0,0,0,0,1,0,0,0,0,0,0));
      step("sw_ex",    0, 0, 0, ov(0,0,0,0,0,0,1,0,1,0,0,0,0));
      step("sw_mem",   0, 1, 0, ov(1,1,1,0,1,0,1,0,0,0,0,1,0));

      // Unknown opcode
      opcode = 7'b1111111;
      step("ill_f",    0, 1, 0, ov(1,0,0,1,0,0,0,0,0,0,0,0,0));
      step("ill_dec",  0, 1, 0, Z);
`ifdef MULTICYCLE_CTRL_TRAP_EN
      step("trap_0",   0, 1, 0, ov(0,0,0,0,0,0,0,0,0,0,0,0,1));
      step("trap_1",   0, 1, 0, ov(0,0,0,0,0,0,0,0,0,0,0,0,1));
      step("trap_2",   0, 1, 1, ov(0,0,0,0,0,0,0,0,0,0,0,0,1));
      step("trap_rst", 1, 0, 0, Z);
      step("trap_idl", 0, 0, 0, Z);
      opcode = 7'b0010011;
      step("trap_re_f",0, 1, 0, ov(1,0,0,1,0,0,0,0,0,0,0,0,0));
`else
      step("nop_ex",   0, 0, 0, ov(0,0,0,0,1,0,0,0,0,0,0,1,0));
      step("nop_next_f",0, 0, 0, ov(1,0,0,0,0,0,0,0,0,0,0,0,0));
      opcode = 7'b0010011;
      step("nop_next_g",0, 1, 0, ov(1,0,0,1,0,0,0,0,0,0,0,0,0));
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control FSM for the multi-cycle RV32I core. It steps every instruction through fetch, decode, execute, memory and writeback. It drives the datapath enables and mux selects, including the immediate-format select feeding the immediate generator, and handshakes with a single shared instruction/data memory port. It sits beside the datapath and sees only the latched opcode, funct3, the branch comparison result and the memory ready signal.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]; forwarded class info only
- branch_taken  in  1  ALU compare result, valid in EXEC
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  write (store); valid with mem_req
- addr_sel  out  1  0=PC, 1=ALU result
- ir_we  out  1  latch instruction register
- pc_we  out  1  update PC
- pc_sel  out  2  0=PC+4, 1=branch/JAL target (PC+imm), 2=JALR target ((rs1+imm)&~1)
- imm_sel  out  3  0=I, 1=S, 2=B, 3=U, 4=J
- alu_src_a  out  1  0=rs1, 1=PC
- alu_src_b  out  1  0=rs2, 1=imm
- reg_we  out  1  register-file write
- wb_sel  out  2  0=ALU, 1=memory data, 2=PC+4
- retire  out  1  one-cycle pulse when an instruction completes
- illegal_instr  out  1  sticky flag (only with MULTICYCLE_CTRL_TRAP_EN)

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP (TRAP only with the macro).
- FETCH: mem_req=1, mem_we=0, addr_sel=0. Stay while !mem_ready. On mem_ready: ir_we=1, go to DECODE.
- DECODE: classify the opcode, then go to EXEC. imm_sel is combinational from opcode in all states: 0010011/0000011/1100111 → I; 0100011 → S; 1100011 → B; 0110111/0010111 → U; 1101111 → J; otherwise 0.
- EXEC:
  - OP/OP-IMM: alu_src_b = imm for OP-IMM, rs2 for OP. Go to WB.
  - LUI/AUIPC: alu_src_b=1; alu_src_a=1 for AUIPC. Go to WB.
  - LOAD/STORE: alu_src_b=1. Go to MEM.
  - BRANCH: pc_we=1, pc_sel = branch_taken ? 1 : 0, retire=1. Go to FETCH.
  - JAL/JALR: go to WB.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for STORE. Stay while !mem_ready. On mem_ready:
  - LOAD → WB.
  - STORE → FETCH, with pc_we=1, pc_sel=0, retire=1.
- WB: reg_we=1, pc_we=1, retire=1, then FETCH.
  - wb_sel=1 for LOAD, 2 for JAL/JALR, else 0.
  - pc_sel=1 for JAL, 2 for JALR, else 0.
- Unknown opcode without the macro: handled as a NOP. EXEC does pc_we=1, pc_sel=0, retire=1, then FETCH.
- mem_we is never asserted without mem_req. reg_we is never asserted outside WB.

## Timing
- Reset: state=FETCH, every output 0, illegal_instr=0. The first mem_req is asserted the cycle after rst deasserts.
- Cycle counts with mem_ready asserted the same cycle as the request:
  - branch, or NOP-treated illegal opcode: 3
  - ALU/LUI/AUIPC/JAL/JALR: 4
  - store: 4
  - load: 5
- Each cycle of mem_ready=0 adds one cycle; mem_req and addr_sel stay stable throughout.
- ir_we, pc_we and retire are single-cycle pulses and are qualified combinationally by mem_ready where listed above.
- rst mid-request drops mem_req the next cycle and returns to FETCH. No partial register or PC write occurs.
- mem_ready while mem_req=0 is ignored.

## Configuration
- MULTICYCLE_CTRL_TRAP_EN defined:
  - Unknown opcode in DECODE → TRAP, with illegal_instr=1 (sticky).
  - No retire or further mem_req until rst.
- Undefined: no TRAP state; illegal_instr is tied 0; unknown opcodes retire as NOPs.

## Structure
- Package multicycle_pkg holds:
  - state enum
  - opcode constants
  - imm_sel, pc_sel and wb_sel code constants
  - these are shared with the datapath muxes and the immediate generator wrapper
- One natural sub-module, ctrl_decode: combinational opcode → instruction class and imm_sel. The FSM lives in multicycle_ctrl.

## Test plan
- Reset, then an ADDI fetch with mem_ready stuck 0 for 3 cycles → mem_req held 4 cycles, ir_we on cycle 4, retire 3 cycles later, reg_we with wb_sel=0 and alu_src_b=1.
- LW with the data phase stalled 2 cycles → mem_we=0 and addr_sel=1 throughout, reg_we with wb_sel=1, total 7 cycles.
- BEQ with branch_taken=1, then with branch_taken=0 → retire in EXEC with pc_sel=1, then pc_sel=0, imm_sel=2, and no reg_we.
- JALR → imm_sel=0, WB with wb_sel=2, pc_sel=2, reg_we=1.
- SW with rst asserted while mem_req is high → all outputs 0 the next cycle, no pc_we, then a clean FETCH restart.
- Opcode 7'b1111111, run once with the macro and once without → TRAP with illegal_instr=1 and no further mem_req; without the macro, retire after 3 cycles and the next fetch proceeds.
